// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754 style adder/subtractor (flush-to-zero, round-to-nearest-even), latency 3 cycles.
// Valid/ready pipeline: each stage advances when empty or drained; in_ready falls only when all three stages hold data.
module fpu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int MW   = MAN_W + 4;  // hidden, fraction, G, R, S
  localparam int SW   = MAN_W + 5;
  localparam int XW   = 16;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic r_live;
  logic r1_vld, r2_vld, r3_vld;
  logic w_ld1, w_ld2, w_ld3, w_acc;

  assign w_ld3     = !r3_vld || out_ready;
  assign w_ld2     = !r2_vld || w_ld3;
  assign w_ld1     = !r1_vld || w_ld2;
  assign in_ready  = r_live && w_ld1;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r3_vld;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb, w_el, w_es, w_diff;
  logic [MAN_W-1:0]   w_fa, w_fb, w_fl, w_fs;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic               w_a_big, w_sl, w_ss, w_far, w_lost;
  logic [31:0]        w_diff32;
  logic [MW-1:0]      w_lext, w_sext, w_shr, w_sal;
  logic               w_spec;
  logic [W-1:0]       w_spres;
  logic [3:0]         w_spflg;

  assign w_sa     = a[W-1];
  assign w_sb     = b[W-1] ^ op;
  assign w_ea     = a[W-2 -: EXP_W];
  assign w_eb     = b[W-2 -: EXP_W];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_fa     = w_a_zero ? '0 : a[MAN_W-1:0];
  assign w_fb     = w_b_zero ? '0 : b[MAN_W-1:0];
  assign w_a_inf  = (&w_ea) && (a[MAN_W-1:0] == '0);
  assign w_b_inf  = (&w_eb) && (b[MAN_W-1:0] == '0);
  assign w_a_nan  = (&w_ea) && (a[MAN_W-1:0] != '0);
  assign w_b_nan  = (&w_eb) && (b[MAN_W-1:0] != '0);
  assign w_a_snan = w_a_nan && !a[MAN_W-1];
  assign w_b_snan = w_b_nan && !b[MAN_W-1];

  assign w_a_big  = {w_ea, w_fa} >= {w_eb, w_fb};
  assign w_sl     = w_a_big ? w_sa : w_sb;
  assign w_ss     = w_a_big ? w_sb : w_sa;
  assign w_el     = w_a_big ? w_ea : w_eb;
  assign w_es     = w_a_big ? w_eb : w_ea;
  assign w_fl     = w_a_big ? w_fa : w_fb;
  assign w_fs     = w_a_big ? w_fb : w_fa;
  assign w_diff   = w_el - w_es;
  assign w_diff32 = 32'(w_diff);

  assign w_lext = {(w_el != '0), w_fl, 3'b000};
  assign w_sext = {(w_es != '0), w_fs, 3'b000};
  assign w_far  = w_diff32 >= 32'(MAN_W + 3);
  assign w_shr  = w_sext >> w_diff;
  assign w_lost = |(w_sext & ~({MW{1'b1}} << w_diff));
  // Far-apart operands only contribute a sticky bit
  assign w_sal  = w_far ? {{(MW-1){1'b0}}, |w_sext} : {w_shr[MW-1:1], w_shr[0] | w_lost};

  always_comb begin
    w_spec  = 1'b0;
    w_spres = '0;
    w_spflg = '0;
    if (w_a_nan || w_b_nan) begin
      w_spec     = 1'b1;
      w_spres    = QNAN;
      w_spflg[3] = w_a_snan || w_b_snan;
    end else if (w_a_inf && w_b_inf) begin
      w_spec = 1'b1;
      if (w_sa != w_sb) begin
        w_spres    = QNAN;
        w_spflg[3] = 1'b1;
      end else begin
        w_spres = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if (w_a_inf) begin
      w_spec  = 1'b1;
      w_spres = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec  = 1'b1;
      w_spres = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_spec  = 1'b1;
      w_spres = {w_sa & w_sb, {(W-1){1'b0}}};
    end
  end

  logic             r1_spec, r1_sgn, r1_sub;
  logic [W-1:0]     r1_spres;
  logic [3:0]       r1_spflg;
  logic [EXP_W-1:0] r1_exp;
  logic [MW-1:0]    r1_ml, r1_ms;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r1_vld   <= 1'b0;
      r1_spec  <= 1'b0;
      r1_sgn   <= 1'b0;
      r1_sub   <= 1'b0;
      r1_spres <= '0;
      r1_spflg <= '0;
      r1_exp   <= '0;
      r1_ml    <= '0;
      r1_ms    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_ld1) r1_vld <= w_acc;
      if (w_acc) begin
        r1_spec  <= w_spec;
        r1_sgn   <= w_sl;
        r1_sub   <= w_sl ^ w_ss;
        r1_spres <= w_spres;
        r1_spflg <= w_spflg;
        r1_exp   <= w_el;
        r1_ml    <= w_lext;
        r1_ms    <= w_sal;
      end
    end
  end

  // ---------------- S2: magnitude add/subtract ----------------
  logic [SW-1:0]    w_sum;
  logic             r2_spec, r2_sgn;
  logic [W-1:0]     r2_spres;
  logic [3:0]       r2_spflg;
  logic [EXP_W-1:0] r2_exp;
  logic [SW-1:0]    r2_sum;

  assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms}) : ({1'b0, r1_ml} + {1'b0, r1_ms});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vld   <= 1'b0;
      r2_spec  <= 1'b0;
      r2_sgn   <= 1'b0;
      r2_spres <= '0;
      r2_spflg <= '0;
      r2_exp   <= '0;
      r2_sum   <= '0;
    end else begin
      if (w_ld2) r2_vld <= r1_vld;
      if (w_ld2 && r1_vld) begin
        r2_spec  <= r1_spec;
        r2_sgn   <= r1_sgn;
        r2_spres <= r1_spres;
        r2_spflg <= r1_spflg;
        r2_exp   <= r1_exp;
        r2_sum   <= w_sum;
      end
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [7:0]            w_lzc;
  logic [MW-1:0]         w_norm;
  logic signed [XW-1:0]  w_ne, w_fe;
  logic                  w_up, w_inx;
  logic [MAN_W+1:0]      w_rnd;
  logic [MAN_W-1:0]      w_frac;
  logic [W-1:0]          w_res;
  logic [3:0]            w_flg;

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < MW; i++) begin
      if (r2_sum[i]) w_lzc = 8'(MW - 1 - i);
    end
  end

  always_comb begin
    if (r2_sum[SW-1]) begin
      w_norm = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
      w_ne   = XW'(r2_exp) + XW'(1);
    end else begin
      w_norm = r2_sum[MW-1:0] << w_lzc;
      w_ne   = XW'(r2_exp) - XW'(w_lzc);
    end
  end

  assign w_inx  = |w_norm[2:0];
  assign w_up   = w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
  assign w_rnd  = {1'b0, w_norm[MW-1:3]} + (MAN_W+2)'(w_up);
  assign w_fe   = w_rnd[MAN_W+1] ? w_ne + XW'(1) : w_ne;
  assign w_frac = w_rnd[MAN_W+1] ? '0 : w_rnd[MAN_W-1:0];

  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (r2_spec) begin
      w_res = r2_spres;
      w_flg = r2_spflg;
    end else if (!w_norm[MW-1]) begin
      w_res = '0;  // exact cancellation
    end else if (w_fe >= XW'(EMAX)) begin
      w_res = {r2_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flg = 4'b0101;
    end else if (w_fe < XW'(1)) begin
      w_res = {r2_sgn, {(W-1){1'b0}}};
      w_flg = 4'b0011;
    end else begin
      w_res = {r2_sgn, w_fe[EXP_W-1:0], w_frac};
      w_flg = {3'b000, w_inx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_vld <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (w_ld3) r3_vld <= r2_vld;
      if (w_ld3 && r2_vld) begin
        result <= w_res;
        flags  <= w_flg;
      end
    end
  end

endmodule
